// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word width, word-select polarity and the receiver state encoding.
package i2s_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  // Word-select level that marks the left slot.
  localparam logic WS_LEFT = 1'b0;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for asynchronous pins, with an optional rising-edge pulse output.
module i2s_sync_edge #(
  parameter int STAGES  = 2,
  parameter int WIDTH   = 1,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic             clk48m,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk48m) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync = stage_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk48m) begin
      if (rst) prev_q <= '0;
      else     prev_q <= sync;
    end

    assign rise = sync & ~prev_q;
  end else begin : g_plain
    assign rise = '0;
  end

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: recovers 16-bit left/right words from sclk/lrclk/din sampled on clk48m.
//   state    | meaning
//   ST_HUNT  | no slot boundary seen yet; waiting for any ws change
//   ST_ALIGN | one boundary seen; waiting for a right->left boundary to start on a frame edge
//   ST_RUN   | slots are completed at each boundary; a right slot publishes the pair
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 256
) (
  input  logic              clk48m,
  input  logic              rst,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              din,
  output logic [WORD_W-1:0] left,
  output logic [WORD_W-1:0] right,
  output logic              frame_valid,
  output logic              locked,
  output logic              short_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic              sclk_rise;
  logic              sclk_sync_unused;
  logic [1:0]        data_sync;
  logic [1:0]        data_rise_unused;
  logic              ws_cur;
  logic              din_s;

  i2s_state_e        state;
  logic              ws_prev_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] left_stage_q;
  logic [TMR_W-1:0]  tmr_q;

  logic [WORD_W-1:0] word_ins;
  logic              boundary;
  logic              timeout;
  logic              slot_short;

  i2s_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk48m  (clk48m),
    .rst     (rst),
    .async_in(sclk),
    .sync    (sclk_sync_unused),
    .rise    (sclk_rise)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(2), .EDGE_EN(1'b0)) u_sync_data (
    .clk48m  (clk48m),
    .rst     (rst),
    .async_in({lrclk, din}),
    .sync    (data_sync),
    .rise    (data_rise_unused)
  );

  assign ws_cur = data_sync[1];
  assign din_s  = data_sync[0];

  // Bits land left-aligned at their final position, so a short slot is zero-filled for free.
  always_comb begin
    word_ins = shreg_q;
    if (!bit_cnt_q[CNT_W-1]) word_ins[4'd15 - bit_cnt_q[3:0]] = din_s;
  end

  assign boundary   = sclk_rise && (ws_cur != ws_prev_q);
  assign timeout    = (tmr_q == TMR_W'(1));
  assign slot_short = (bit_cnt_q < CNT_W'(WORD_W - 1));

  always_ff @(posedge clk48m) begin
    if (rst) begin
      state        <= ST_HUNT;
      ws_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      left_stage_q <= '0;
      tmr_q        <= '0;
      left         <= '0;
      right        <= '0;
      frame_valid  <= 1'b0;
      locked       <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;

      // Down-counter reloads on every bit clock; reaching zero means the bit clock has stopped.
      if (sclk_rise)          tmr_q <= TMR_W'(TIMEOUT);
      else if (tmr_q != '0)   tmr_q <= tmr_q - TMR_W'(1);

      if (sclk_rise) ws_prev_q <= ws_cur;

      if (timeout) begin
        state     <= ST_HUNT;
        bit_cnt_q <= '0;
        shreg_q   <= '0;
        locked    <= 1'b0;
      end else if (boundary) begin
        bit_cnt_q <= '0;
        shreg_q   <= '0;
        case (state)
          ST_HUNT:  state <= ST_ALIGN;
          ST_ALIGN: if (ws_prev_q != WS_LEFT && ws_cur == WS_LEFT) state <= ST_RUN;
          ST_RUN: begin
            if (slot_short) short_err <= 1'b1;
            if (ws_prev_q == WS_LEFT) begin
              left_stage_q <= word_ins;
            end else begin
              left        <= left_stage_q;
              right       <= word_ins;
              frame_valid <= 1'b1;
              locked      <= 1'b1;
            end
          end
          default:  state <= ST_HUNT;
        endcase
      end else if (sclk_rise && !bit_cnt_q[CNT_W-1]) begin
        shreg_q   <= word_ins;
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: an I2S master BFM with hand-computed expected words.
module tb_i2s_receiver;

  localparam int H = 16;   // sclk half period in clk48m cycles (1.5 MHz bit clock)

  logic        clk48m = 1'b0;
  logic        rst    = 1'b1;
  logic        sclk   = 1'b0;
  logic        lrclk  = 1'b0;
  logic        din    = 1'b0;
  logic [15:0] left;
  logic [15:0] right;
  logic        frame_valid;
  logic        locked;
  logic        short_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int fv_cnt = 0;
  int fv_last = 0;
  int fv_prev = 0;

  i2s_receiver #(.SYNC_STAGES(2), .TIMEOUT(256)) dut (
    .clk48m     (clk48m),
    .rst        (rst),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .din        (din),
    .left       (left),
    .right      (right),
    .frame_valid(frame_valid),
    .locked     (locked),
    .short_err  (short_err)
  );

  always #10 clk48m = ~clk48m;

  always @(negedge clk48m) begin
    cyc++;
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      fv_prev = fv_last;
      fv_last = cyc;
    end
  end

  task automatic send_bit(input logic ws, input logic d);
    sclk  = 1'b0;
    lrclk = ws;
    din   = d;
    repeat (H) @(negedge clk48m);
    sclk = 1'b1;
    repeat (H) @(negedge clk48m);
  endtask

  // Positions first..last of one frame of n-bit slots; ws leads the data by one bit.
  task automatic send_range(input logic [31:0] lw, input logic [31:0] rw, input int n,
                            input int first, input int last);
    logic d;
    logic ws;
    for (int j = first; j <= last; j++) begin
      d  = (j < n) ? lw[n-1-j] : rw[2*n-1-j];
      ws = (((j + 1) % (2 * n)) >= n);
      send_bit(ws, d);
    end
  endtask

  task automatic send_frames(input logic [31:0] lw, input logic [31:0] rw, input int n,
                             input int k);
    for (int f = 0; f < k; f++) send_range(lw, rw, n, 0, 2 * n - 1);
  endtask

  task automatic do_reset();
    @(negedge clk48m);
    rst = 1'b1;
    repeat (2) @(negedge clk48m);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk48m);
    rst = 1'b1;
    repeat (2) @(negedge clk48m);
    n_cmp++; if (left !== 16'h0)      begin n_fail++; $display("FAIL reset_left got %h want 0000", left); end
    n_cmp++; if (right !== 16'h0)     begin n_fail++; $display("FAIL reset_right got %h want 0000", right); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    n_cmp++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (short_err !== 1'b0)  begin n_fail++; $display("FAIL reset_short got %b want 0", short_err); end
    rst = 1'b0;
  endtask

  task automatic test_bfm_basic();
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    send_frames(32'h8001, 32'h7FFE, 16, 3);
    n_cmp++; if (left !== 16'h8001)   begin n_fail++; $display("FAIL basic_left got %h want 8001", left); end
    n_cmp++; if (right !== 16'h7FFE)  begin n_fail++; $display("FAIL basic_right got %h want 7ffe", right); end
    n_cmp++; if (short_err !== 1'b0)  begin n_fail++; $display("FAIL basic_short got %b want 0", short_err); end
    n_cmp++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL basic_locked got %b want 1", locked); end
    n_cmp++; if (fv_cnt - fv0 !== 2)  begin n_fail++; $display("FAIL basic_fv_count got %0d want 2", fv_cnt - fv0); end
  endtask

  task automatic test_frame_rate();
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    send_frames(32'h048D, 32'h048D, 16, 4);
    n_cmp++; if (left !== 16'h048D)   begin n_fail++; $display("FAIL rate_left got %h want 048d", left); end
    n_cmp++; if (right !== 16'h048D)  begin n_fail++; $display("FAIL rate_right got %h want 048d", right); end
    n_cmp++; if (fv_cnt - fv0 !== 3)  begin n_fail++; $display("FAIL rate_fv_count got %0d want 3", fv_cnt - fv0); end
    n_cmp++; if (fv_last - fv_prev !== 1024)
      begin n_fail++; $display("FAIL rate_fv_spacing got %0d want 1024", fv_last - fv_prev); end
  endtask

  task automatic test_long_slots();
    do_reset();
    send_frames(32'hABCDE, 32'h12345, 20, 3);
    n_cmp++; if (left !== 16'hABCD)   begin n_fail++; $display("FAIL long_left got %h want abcd", left); end
    n_cmp++; if (right !== 16'h1234)  begin n_fail++; $display("FAIL long_right got %h want 1234", right); end
    n_cmp++; if (short_err !== 1'b0)  begin n_fail++; $display("FAIL long_short got %b want 0", short_err); end
  endtask

  task automatic test_short_slots();
    do_reset();
    send_frames(32'hFFF, 32'h0A5, 12, 3);
    n_cmp++; if (left !== 16'hFFF0)   begin n_fail++; $display("FAIL short_left got %h want fff0", left); end
    n_cmp++; if (right !== 16'h0A50)  begin n_fail++; $display("FAIL short_right got %h want 0a50", right); end
    n_cmp++; if (short_err !== 1'b1)  begin n_fail++; $display("FAIL short_flag got %b want 1", short_err); end
  endtask

  task automatic test_timeout();
    int fv0;
    do_reset();
    send_frames(32'h1111, 32'h2222, 16, 3);
    repeat (200) @(negedge clk48m);
    n_cmp++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL to_locked_before got %b want 1", locked); end
    repeat (100) @(negedge clk48m);
    n_cmp++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL to_locked_after got %b want 0", locked); end
    n_cmp++; if (left !== 16'h1111)   begin n_fail++; $display("FAIL to_left_hold got %h want 1111", left); end
    n_cmp++; if (right !== 16'h2222)  begin n_fail++; $display("FAIL to_right_hold got %h want 2222", right); end
    fv0 = fv_cnt;
    send_frames(32'h3333, 32'h4444, 16, 1);
    n_cmp++; if (fv_cnt - fv0 !== 0)  begin n_fail++; $display("FAIL to_relock_early got %0d want 0", fv_cnt - fv0); end
    send_frames(32'h3333, 32'h4444, 16, 1);
    n_cmp++; if (fv_cnt - fv0 !== 1)  begin n_fail++; $display("FAIL to_relock_fv got %0d want 1", fv_cnt - fv0); end
    n_cmp++; if (left !== 16'h3333)   begin n_fail++; $display("FAIL to_relock_left got %h want 3333", left); end
    n_cmp++; if (right !== 16'h4444)  begin n_fail++; $display("FAIL to_relock_right got %h want 4444", right); end
    n_cmp++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL to_relock_locked got %b want 1", locked); end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    do_reset();
    send_frames(32'h5555, 32'hAAAA, 16, 3);
    send_range(32'h1357, 32'h2468, 16, 0, 20);
    rst = 1'b1;
    @(negedge clk48m);
    n_cmp++; if (left !== 16'h0)       begin n_fail++; $display("FAIL mid_left got %h want 0000", left); end
    n_cmp++; if (right !== 16'h0)      begin n_fail++; $display("FAIL mid_right got %h want 0000", right); end
    n_cmp++; if (locked !== 1'b0)      begin n_fail++; $display("FAIL mid_locked got %b want 0", locked); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL mid_fv got %b want 0", frame_valid); end
    rst = 1'b0;
    fv0 = fv_cnt;
    send_range(32'h1357, 32'h2468, 16, 21, 31);
    n_cmp++; if (fv_cnt - fv0 !== 0)   begin n_fail++; $display("FAIL mid_partial_fv got %0d want 0", fv_cnt - fv0); end
    send_frames(32'h1357, 32'h2468, 16, 1);
    n_cmp++; if (fv_cnt - fv0 !== 1)   begin n_fail++; $display("FAIL mid_new_fv got %0d want 1", fv_cnt - fv0); end
    n_cmp++; if (left !== 16'h1357)    begin n_fail++; $display("FAIL mid_new_left got %h want 1357", left); end
    n_cmp++; if (right !== 16'h2468)   begin n_fail++; $display("FAIL mid_new_right got %h want 2468", right); end
  endtask

  initial begin
    test_reset();
    test_bfm_basic();
    test_frame_rate();
    test_long_slots();
    test_short_slots();
    test_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per asynchronous input (legal 2..3).
REQ-002 SHALL have parameter TIMEOUT, default 256, count of clk48m cycles without an sclk rising edge that drops lock (legal 64..4095).
REQ-003 SHALL have port clk48m, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port sclk, input, 1, external I2S bit clock, asynchronous to clk48m, at most clk48m/8.
REQ-006 SHALL have port lrclk, input, 1, external word select, asynchronous: 0 = left slot, 1 = right slot.
REQ-007 SHALL have port din, input, 1, external serial data, MSB first, asynchronous.
REQ-008 SHALL have port left, output, 16, last completed left word, two's complement.
REQ-009 SHALL have port right, output, 16, last completed right word.
REQ-010 SHALL have port frame_valid, output, 1, one-cycle pulse when a left/right pair is updated.
REQ-011 SHALL have port locked, output, 1, high while a valid frame stream is being received.
REQ-012 SHALL have port short_err, output, 1, sticky flag: a slot ended with fewer than 16 bits.

Function
REQ-013 SHALL pass sclk, lrclk and din through SYNC_STAGES-flop synchronizers, then detect sclk rising edges with one extra register (sclk_rise).
REQ-014 SHALL sample synced din and lrclk only on cycles where sclk_rise is high; the sampled lrclk is called ws.
REQ-015 SHALL define a slot boundary as an sclk_rise where ws differs from the ws of the previous sclk_rise; the din bit sampled at the boundary is the LSB position of the ending slot (standard I2S one-bit delay).
REQ-016 SHALL shift bits MSB first into a 16-bit shift register using a 5-bit bit counter cleared at each boundary; bits beyond the 16th in a slot are ignored (counter saturates at 16).
REQ-017 SHALL, at each boundary in state RUN, complete the slot word: bits received left-aligned, missing LSBs zero-filled; the ending slot is left if previous ws = 0, right if 1.
REQ-018 SHALL hold a completed left word in a staging register and update outputs left and right together, asserting frame_valid for exactly one clk48m cycle, on the cycle after the right-slot boundary sclk_rise.
REQ-019 SHALL assert short_err when a completed slot had bit count < 16 (boundary bit included); short_err clears only on rst.
REQ-020 SHALL implement states HUNT, ALIGN, RUN: HUNT -> ALIGN on first boundary; ALIGN -> RUN on the next boundary of a right->left transition; words are completed only in RUN; partial slots before RUN are discarded.
REQ-021 SHALL assert locked on the first frame_valid and deassert it on timeout.
REQ-022 SHALL count clk48m cycles since the last sclk_rise; on reaching TIMEOUT, go to HUNT, clear the bit counter, and deassert locked; left and right hold their values.
REQ-023 SHALL give a boundary and a timeout occurring in the same cycle the priority of the timeout.
REQ-024 SHALL keep frame_valid latency from a pin-level sclk rising edge of SYNC_STAGES+1 to SYNC_STAGES+2 clk48m cycles.

Reset
REQ-025 SHALL, when rst is high at a clk48m edge, set state HUNT, synchronizers 0, left 0, right 0, frame_valid 0, locked 0, short_err 0, counters 0.
REQ-026 SHALL discard any partially received word when reset is asserted mid-frame; reception restarts in HUNT.

Structure
REQ-027 SHALL place the state encoding (HUNT/ALIGN/RUN), the word width 16 and the channel polarity constant in a shared package i2s_pkg, used also by the transmitter.
REQ-028 SHALL use one sub-module, i2s_sync_edge: a parameterized synchronizer with rising-edge output, instantiated for sclk; lrclk and din use its plain synchronizer mode.

Verification
REQ-029 SHALL cover loopback with the team's 48 MHz transmitter, signal = 16'h1234: after lock, left = right = 16'h048D and frame_valid pulses every 1024 clk48m cycles.
REQ-030 SHALL cover a BFM at sclk = 1.5 MHz sending left 16'h8001, right 16'h7FFE: left = 16'h8001, right = 16'h7FFE, short_err = 0.
REQ-031 SHALL cover 20-bit slots with left 20'hABCDE: left = 16'hABCD, extra bits ignored, short_err = 0.
REQ-032 SHALL cover 12-bit slots with left 12'hFFF: left = 16'hFFF0 and short_err = 1.
REQ-033 SHALL cover sclk stopped for TIMEOUT cycles: locked falls, left and right hold, and after restart the first frame_valid comes only after HUNT -> ALIGN -> RUN.
REQ-034 SHALL cover rst asserted mid right slot: all outputs 0 next cycle, no frame_valid until a full new frame.
